// File: rtl/systolic_skew_feeder.sv
// systolic_skew_feeder
// Upstream stage of the 8x8 hPE tile. Takes one K-slice per beat (A column
// and B row) and re-times it into the diagonal wavefront the tile expects.
// Row lane i and column lane j see i and j extra steps of delay, and the
// lanes read zero wherever no beat is present. The block also drives the
// tile enable, pulses an accumulator clear at job start, and flushes the
// array with 2N-1 zero steps after the last beat.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for start with a non-zero k_len
// LOAD   | clear pulse cycle, then accepting beats until k_len are taken
// FLUSH  | injecting zero steps to drain the wavefront out of the tile

module systolic_skew_feeder #(
  parameter int N  = 8,
  parameter int DW = 16,
  parameter int KW = 8
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            start,
  input  logic [KW-1:0]   k_len,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N*DW-1:0] a_col,
  input  logic [N*DW-1:0] b_row,
  output logic [N*DW-1:0] row_out,
  output logic [N*DW-1:0] col_out,
  output logic            pe_en,
  output logic            pe_clr,
  output logic            busy,
  output logic            done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  localparam int FLUSH_STEPS = 2 * N - 1;
  localparam int FW          = $clog2(FLUSH_STEPS + 1);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_STEPS - 1);

  state_t state_q;
  state_t state_d;

  logic [KW-1:0] k_len_q;
  logic [KW-1:0] beat_cnt_q;
  logic [FW-1:0] flush_cnt_q;

  logic start_ok;
  logic accept;
  logic step;
  logic inject_zero;
  logic last_beat;
  logic last_flush;
  logic last_step_q;

  // State register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (last_beat) begin
          state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (last_flush) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output / handshake decode; the clear cycle is never ready so no beat
  // can land on top of the accumulator clear
  always_comb begin
    start_ok    = 1'b0;
    in_ready    = 1'b0;
    inject_zero = 1'b0;
    busy        = (state_q != S_IDLE);
    case (state_q)
      S_IDLE:  start_ok    = start && (k_len != '0);
      S_LOAD:  in_ready    = !pe_clr;
      S_FLUSH: inject_zero = 1'b1;
      default: ;
    endcase
    accept     = in_valid && in_ready;
    step       = accept || inject_zero;
    last_beat  = accept && (beat_cnt_q == k_len_q - KW'(1));
    last_flush = inject_zero && (flush_cnt_q == FLUSH_LAST);
  end

  // Job length latch plus beat and flush counters
  always_ff @(posedge CLK) begin
    if (RST) begin
      k_len_q     <= '0;
      beat_cnt_q  <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (start_ok) begin
        k_len_q    <= k_len;
        beat_cnt_q <= '0;
      end else if (accept) begin
        beat_cnt_q <= beat_cnt_q + KW'(1);
      end
      if (last_beat) begin
        flush_cnt_q <= '0;
      end else if (inject_zero) begin
        flush_cnt_q <= flush_cnt_q + FW'(1);
      end
    end
  end

  // Tile control pulses: clear lands in the first LOAD cycle, enable mirrors
  // the step that just moved the outputs, done follows the final enable
  always_ff @(posedge CLK) begin
    if (RST) begin
      pe_clr      <= 1'b0;
      pe_en       <= 1'b0;
      last_step_q <= 1'b0;
      done        <= 1'b0;
    end else begin
      pe_clr      <= start_ok;
      pe_en       <= step;
      last_step_q <= last_flush;
      done        <= last_step_q;
    end
  end

  // Per-lane skew chains; lane g is g+1 registers deep and its last stage
  // drives the tile edge directly
  for (genvar g = 0; g < N; g++) begin : g_lane
    logic [DW-1:0] a_chain [0:g];
    logic [DW-1:0] b_chain [0:g];
    logic [DW-1:0] a_in;
    logic [DW-1:0] b_in;

    assign a_in = inject_zero ? '0 : a_col[g*DW +: DW];
    assign b_in = inject_zero ? '0 : b_row[g*DW +: DW];

    // Shift one position per step, hold on bubbles
    always_ff @(posedge CLK) begin
      if (RST) begin
        for (int d = 0; d <= g; d++) begin
          a_chain[d] <= '0;
          b_chain[d] <= '0;
        end
      end else if (step) begin
        a_chain[0] <= a_in;
        b_chain[0] <= b_in;
        for (int d = 1; d <= g; d++) begin
          a_chain[d] <= a_chain[d-1];
          b_chain[d] <= b_chain[d-1];
        end
      end
    end

    assign row_out[g*DW +: DW] = a_chain[g];
    assign col_out[g*DW +: DW] = b_chain[g];
  end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Bench for systolic_skew_feeder: scoreboard of expected edge vectors per
// enabled step, plus a behavioural 8x8 output-stationary tile fed by the
// feeder whose accumulators are compared against A*B at job end.

module tb_systolic_skew_feeder;

  localparam int N  = 8;
  localparam int DW = 16;
  localparam int KW = 8;
  localparam int W  = N * DW;
  localparam int KMAX = 16;

  logic          CLK;
  logic          RST;
  logic          start;
  logic [KW-1:0] k_len;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a_col;
  logic [W-1:0]  b_row;
  logic [W-1:0]  row_out;
  logic [W-1:0]  col_out;
  logic          pe_en;
  logic          pe_clr;
  logic          busy;
  logic          done;

  systolic_skew_feeder #(.N(N), .DW(DW), .KW(KW)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .start    (start),
    .k_len    (k_len),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a_col    (a_col),
    .b_row    (b_row),
    .row_out  (row_out),
    .col_out  (col_out),
    .pe_en    (pe_en),
    .pe_clr   (pe_clr),
    .busy     (busy),
    .done     (done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [W-1:0] row;
    logic [W-1:0] col;
  } sb_t;

  sb_t sb_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  int ma [N][KMAX];
  int mb [KMAX][N];

  int acc [N][N];
  int ta  [N][N];
  int tb  [N][N];

  int pe_en_cnt = 0;
  int done_cnt  = 0;
  int clr_cnt   = 0;

  task automatic chk_eq(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp_v);
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  // Monitor: scoreboard pop, hold check, tile model, pulse bookkeeping
  initial begin
    logic [W-1:0] prev_row;
    logic [W-1:0] prev_col;
    logic         prev_rst;
    logic         prev_pe_en;
    sb_t          e;
    int           a_in;
    int           b_in;
    prev_row   = '0;
    prev_col   = '0;
    prev_rst   = 1'b1;
    prev_pe_en = 1'b0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        acc[i][j] = 0; ta[i][j] = 0; tb[i][j] = 0;
      end
    forever begin
      @(negedge CLK);
      if (pe_en) begin
        pe_en_cnt++;
        if (sb_q.size() == 0) begin
          chk_eq("pe_en_extra", W'(pe_en), W'(0));
        end else begin
          e = sb_q.pop_front();
          chk_eq("row_out", row_out, e.row);
          chk_eq("col_out", col_out, e.col);
        end
        for (int i = N - 1; i >= 0; i--)
          for (int j = N - 1; j >= 0; j--) begin
            a_in = (j == 0) ? int'(row_out[i*DW +: DW]) : ta[i][j-1];
            b_in = (i == 0) ? int'(col_out[j*DW +: DW]) : tb[i-1][j];
            acc[i][j] += a_in * b_in;
            ta[i][j] = a_in;
            tb[i][j] = b_in;
          end
      end else if (!prev_rst) begin
        chk_eq("row_hold", row_out, prev_row);
        chk_eq("col_hold", col_out, prev_col);
      end
      if (pe_clr) begin
        clr_cnt++;
        chk_eq("in_ready_in_clr", W'(in_ready), W'(0));
        for (int i = 0; i < N; i++)
          for (int j = 0; j < N; j++) begin
            acc[i][j] = 0; ta[i][j] = 0; tb[i][j] = 0;
          end
      end
      if (done) begin
        done_cnt++;
        chk_eq("done_after_pe_en", W'(prev_pe_en), W'(1));
        chk_eq("sb_drained_at_done", W'(sb_q.size()), W'(0));
      end
      prev_row   = row_out;
      prev_col   = col_out;
      prev_pe_en = pe_en;
      prev_rst   = RST;
    end
  end

  // Drive one job; optional bubble gap, mid-LOAD restart, reset in FLUSH
  task automatic run_job(input int k, input int gap_after, input int gap_len,
                         input bit restart, input bit rst_flush);
    int  d0, p0, c0, b, cyc, gap_left, ki, kj, expv;
    bit  acc_now, restarted;
    sb_t e;
    d0 = done_cnt; p0 = pe_en_cnt; c0 = clr_cnt;
    for (int s = 0; s < k + 2 * N - 1; s++) begin
      e.row = '0;
      e.col = '0;
      for (int i = 0; i < N; i++) begin
        ki = s - i;
        if (ki >= 0 && ki < k) begin
          e.row[i*DW +: DW] = DW'(ma[i][ki]);
          e.col[i*DW +: DW] = DW'(mb[ki][i]);
        end
      end
      sb_q.push_back(e);
    end
    start = 1'b1;
    k_len = KW'(k);
    @(posedge CLK); #1;
    start = 1'b0;
    chk_eq("pe_clr_first_load", W'(pe_clr), W'(1));
    chk_eq("busy_in_load", W'(busy), W'(1));
    b = 0; cyc = 0; gap_left = gap_len; restarted = 1'b0;
    while (b < k && cyc < 200) begin
      if (b == gap_after && gap_left > 0) begin
        in_valid = 1'b0;
        gap_left--;
      end else begin
        in_valid = 1'b1;
        for (int i = 0; i < N; i++) begin
          a_col[i*DW +: DW] = DW'(ma[i][b]);
          b_row[i*DW +: DW] = DW'(mb[b][i]);
        end
      end
      if (restart && b == 2 && !restarted) begin
        start = 1'b1;
        k_len = KW'(5);
        restarted = 1'b1;
      end else begin
        start = 1'b0;
      end
      acc_now = in_valid && in_ready;
      @(posedge CLK); #1;
      cyc++;
      if (acc_now) b++;
    end
    in_valid = 1'b0;
    start = 1'b0;
    a_col = '0;
    b_row = '0;
    chk_eq("beats_accepted", W'(b), W'(k));
    if (rst_flush) begin
      @(posedge CLK); #1;
      @(posedge CLK); #1;
      RST = 1'b1;
      @(posedge CLK); #1;
      RST = 1'b0;
      sb_q.delete();
      chk_eq("rst_row_out", row_out, '0);
      chk_eq("rst_col_out", col_out, '0);
      chk_eq("rst_busy", W'(busy), W'(0));
      chk_eq("rst_pe_en", W'(pe_en), W'(0));
      chk_eq("rst_done", W'(done), W'(0));
      chk_eq("rst_in_ready", W'(in_ready), W'(0));
      repeat (20) @(posedge CLK);
      #1;
      chk_eq("rst_no_done", W'(done_cnt - d0), W'(0));
    end else begin
      for (int c = 0; c < 60 && done_cnt == d0; c++) @(posedge CLK);
      #1;
      repeat (4) @(posedge CLK);
      #1;
      chk_eq("done_pulses", W'(done_cnt - d0), W'(1));
      chk_eq("pe_en_cycles", W'(pe_en_cnt - p0), W'(k + 2 * N - 1));
      chk_eq("clr_pulses", W'(clr_cnt - c0), W'(1));
      chk_eq("busy_after_done", W'(busy), W'(0));
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          expv = 0;
          for (int kk = 0; kk < k; kk++) expv += ma[i][kk] * mb[kk][j];
          chk_eq($sformatf("tile_c_%0d_%0d", i, j), W'(acc[i][j]), W'(expv));
        end
    end
  endtask

  task automatic clear_mats();
    for (int i = 0; i < N; i++)
      for (int kk = 0; kk < KMAX; kk++) begin
        ma[i][kk] = 0;
        mb[kk][i] = 0;
      end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, c0;
    RST = 1'b1; start = 1'b0; k_len = '0; in_valid = 1'b0;
    a_col = '0; b_row = '0;
    repeat (3) @(posedge CLK);
    #1;
    chk_eq("reset_row_out", row_out, '0);
    chk_eq("reset_col_out", col_out, '0);
    chk_eq("reset_pe_en", W'(pe_en), W'(0));
    chk_eq("reset_pe_clr", W'(pe_clr), W'(0));
    chk_eq("reset_in_ready", W'(in_ready), W'(0));
    chk_eq("reset_busy", W'(busy), W'(0));
    chk_eq("reset_done", W'(done), W'(0));
    RST = 1'b0;
    @(posedge CLK); #1;

    // K=1, lanes 1..8 and 10..17
    clear_mats();
    for (int i = 0; i < N; i++) begin
      ma[i][0] = i + 1;
      mb[0][i] = 10 + i;
    end
    run_job(1, -1, 0, 1'b0, 1'b0);

    // K=8, identity times B with B[k][j] = 16k+j
    clear_mats();
    for (int i = 0; i < N; i++)
      for (int kk = 0; kk < N; kk++) begin
        ma[i][kk] = (i == kk) ? 1 : 0;
        mb[kk][i] = 16 * kk + i;
      end
    run_job(8, -1, 0, 1'b0, 1'b0);

    // K=4 random data, no gap then a 3-cycle bubble after beat 1
    clear_mats();
    for (int i = 0; i < N; i++)
      for (int kk = 0; kk < 4; kk++) begin
        ma[i][kk] = int'($urandom_range(0, 255));
        mb[kk][i] = int'($urandom_range(0, 255));
      end
    run_job(4, -1, 0, 1'b0, 1'b0);
    run_job(4, 2, 3, 1'b0, 1'b0);

    // K=3 with start/k_len=5 pulsed mid-LOAD
    clear_mats();
    for (int i = 0; i < N; i++)
      for (int kk = 0; kk < 3; kk++) begin
        ma[i][kk] = i + kk + 1;
        mb[kk][i] = 3 * kk + i + 2;
      end
    run_job(3, -1, 0, 1'b1, 1'b0);

    // Reset in the 3rd FLUSH cycle, then a clean job
    run_job(4, -1, 0, 1'b0, 1'b1);
    clear_mats();
    for (int i = 0; i < N; i++)
      for (int kk = 0; kk < 2; kk++) begin
        ma[i][kk] = int'($urandom_range(1, 100));
        mb[kk][i] = int'($urandom_range(1, 100));
      end
    run_job(2, -1, 0, 1'b0, 1'b0);

    // start with k_len=0 is ignored
    d0 = done_cnt; c0 = clr_cnt;
    start = 1'b1;
    k_len = '0;
    @(posedge CLK); #1;
    start = 1'b0;
    chk_eq("klen0_busy", W'(busy), W'(0));
    chk_eq("klen0_pe_clr", W'(pe_clr), W'(0));
    repeat (5) @(posedge CLK);
    #1;
    chk_eq("klen0_no_done", W'(done_cnt - d0), W'(0));
    chk_eq("klen0_no_clr", W'(clr_cnt - c0), W'(0));
    chk_eq("klen0_idle", W'(busy), W'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
